// File: rtl/change_dispenser.sv
// change_dispenser: pays out a 0/5/10/15-unit change amount as individual
// coins through a per-coin req/ack handshake with the hopper. 10-unit coins
// go first, then 5-unit coins. All outputs are decoded from registered state.
module change_dispenser #(
  parameter int AMT_W   = 4,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             chg_valid,
  input  logic [AMT_W-1:0] chg_amt,
  output logic             chg_ready,
  output logic             coin_req,
  output logic             coin_sel,
  input  logic             coin_ack,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             fault,
  output logic [CNT_W-1:0] cnt10,
  output logic [CNT_W-1:0] cnt5
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GAP,
    DONE,
    FAULT
  } state_t;

  localparam logic [AMT_W-1:0] AMT_0  = AMT_W'(0);
  localparam logic [AMT_W-1:0] AMT_5  = AMT_W'(5);
  localparam logic [AMT_W-1:0] AMT_10 = AMT_W'(10);
  localparam logic [AMT_W-1:0] AMT_15 = AMT_W'(15);
  localparam logic [7:0]       T_LAST = 8'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [AMT_W-1:0] rem, rem_nx;
  logic [7:0]       timer, timer_nx;
  logic             err_q, err_nx;
  logic [CNT_W-1:0] cnt10_q, cnt5_q;
  logic             big_coin;
  logic             inc10, inc5;
  logic             amt_legal;

  assign big_coin  = (rem >= AMT_10);
  assign amt_legal = (chg_amt == AMT_0) || (chg_amt == AMT_5) ||
                     (chg_amt == AMT_10) || (chg_amt == AMT_15);

  // State, remainder, timer and error pulse registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      rem   <= '0;
      timer <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
      timer <= timer_nx;
      err_q <= err_nx;
    end
  end

  // Next-state logic for the payout sequence
  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    timer_nx = timer;
    err_nx   = 1'b0;
    inc10    = 1'b0;
    inc5     = 1'b0;
    unique case (state)
      IDLE: begin
        if (chg_valid) begin
          if (!amt_legal) begin
            err_nx = 1'b1;
          end else if (chg_amt == AMT_0) begin
            state_nx = DONE;
          end else begin
            rem_nx   = chg_amt;
            timer_nx = '0;
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        if (coin_ack) begin
          if (big_coin) begin
            rem_nx = rem - AMT_10;
            inc10  = 1'b1;
          end else begin
            rem_nx = rem - AMT_5;
            inc5   = 1'b1;
          end
          state_nx = GAP;
        end else if (timer == T_LAST) begin
          state_nx = FAULT;
        end else begin
          timer_nx = timer + 8'd1;
        end
      end
      GAP: begin
        if (rem == AMT_0) begin
          state_nx = DONE;
        end else begin
          timer_nx = '0;
          state_nx = REQ;
        end
      end
      DONE:    state_nx = IDLE;
      FAULT:   state_nx = FAULT;
      default: state_nx = IDLE;
    endcase
  end

  // Saturating dispensed-coin counters
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt10_q <= '0;
      cnt5_q  <= '0;
    end else begin
      if (inc10 && (cnt10_q != '1)) cnt10_q <= cnt10_q + CNT_W'(1);
      if (inc5  && (cnt5_q  != '1)) cnt5_q  <= cnt5_q  + CNT_W'(1);
    end
  end

  // Output decode from registered state; rem is constant during REQ, so
  // coin_sel stays stable for the whole request
  always_comb begin
    chg_ready = (state == IDLE);
    coin_req  = (state == REQ);
    coin_sel  = (state == REQ) && big_coin;
    busy      = (state == REQ) || (state == GAP);
    done      = (state == DONE);
    fault     = (state == FAULT);
    err       = err_q;
    cnt10     = cnt10_q;
    cnt5      = cnt5_q;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: a fixed vector table, directed corner
// sequences and randomized traffic, all checked against a coin-queue model.
module tb_change_dispenser;

  localparam int TO = 8;

  logic       clock;
  logic       reset;
  logic       chg_valid;
  logic [3:0] chg_amt;
  logic       chg_ready;
  logic       coin_req;
  logic       coin_sel;
  logic       coin_ack;
  logic       busy;
  logic       done;
  logic       err;
  logic       fault;
  logic [7:0] cnt10;
  logic [7:0] cnt5;

  change_dispenser #(.AMT_W(4), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .chg_valid(chg_valid), .chg_amt(chg_amt), .chg_ready(chg_ready),
    .coin_req(coin_req), .coin_sel(coin_sel), .coin_ack(coin_ack),
    .busy(busy), .done(done), .err(err), .fault(fault),
    .cnt10(cnt10), .cnt5(cnt5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending coins as a queue of coin types (1 = ten).
  bit m_req, m_gap, m_done, m_err, m_fault;
  bit coins[$];
  int m_wait, m_c10, m_c5;

  function automatic void model_update(bit r, bit v, logic [3:0] a, bit k);
    int rest;
    if (r) begin
      m_req = 0; m_gap = 0; m_done = 0; m_err = 0; m_fault = 0;
      coins.delete(); m_wait = 0; m_c10 = 0; m_c5 = 0;
      return;
    end
    m_err = 0;
    if (m_fault) begin
    end else if (m_done) begin
      m_done = 0;
    end else if (m_req) begin
      if (k) begin
        if (coins[0]) m_c10 = (m_c10 == 255) ? 255 : m_c10 + 1;
        else          m_c5  = (m_c5  == 255) ? 255 : m_c5 + 1;
        void'(coins.pop_front());
        m_req = 0;
        m_gap = 1;
      end else if (m_wait == TO - 1) begin
        m_req = 0;
        m_fault = 1;
      end else begin
        m_wait++;
      end
    end else if (m_gap) begin
      m_gap = 0;
      if (coins.size() == 0) m_done = 1;
      else begin m_req = 1; m_wait = 0; end
    end else if (v) begin
      rest = int'(a);
      if (rest % 5 != 0) m_err = 1;
      else if (rest == 0) m_done = 1;
      else begin
        while (rest >= 10) begin coins.push_back(1'b1); rest -= 10; end
        while (rest >= 5)  begin coins.push_back(1'b0); rest -= 5;  end
        m_req = 1;
        m_wait = 0;
      end
    end
  endfunction

  task automatic check_model(input string tag);
    bit e_sel;
    e_sel = m_req ? coins[0] : 1'b0;
    chk({tag, " ready"}, int'(chg_ready), int'(!(m_req || m_gap || m_done || m_fault)));
    chk({tag, " req"},   int'(coin_req),  int'(m_req));
    chk({tag, " sel"},   int'(coin_sel),  int'(e_sel));
    chk({tag, " busy"},  int'(busy),      int'(m_req || m_gap));
    chk({tag, " done"},  int'(done),      int'(m_done));
    chk({tag, " err"},   int'(err),       int'(m_err));
    chk({tag, " fault"}, int'(fault),     int'(m_fault));
    chk({tag, " cnt10"}, int'(cnt10),     m_c10);
    chk({tag, " cnt5"},  int'(cnt5),      m_c5);
  endtask

  // Apply inputs for one cycle, advance model on the edge, compare after it
  task automatic step(input string tag, input bit r, input bit v,
                      input logic [3:0] a, input bit k);
    reset = r; chg_valid = v; chg_amt = a; coin_ack = k;
    @(posedge clock);
    model_update(r, v, a, k);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit       rst, v;
    bit [3:0] amt;
    bit       ack;
    bit       ready, req, sel, dn, er, flt, bsy;
    int       c10, c5;
  } vec_t;

  vec_t tbl[12];
  int   nreq;

  initial begin
    reset = 1'b1; chg_valid = 1'b0; chg_amt = '0; coin_ack = 1'b0;

    //           rst v amt ack  rdy req sel dn er flt bsy c10 c5
    tbl[0]  = '{1, 0, 0,  0,   1,  0,  0,  0, 0, 0,  0,  0, 0};
    tbl[1]  = '{1, 0, 0,  0,   1,  0,  0,  0, 0, 0,  0,  0, 0};
    tbl[2]  = '{0, 1, 15, 1,   0,  1,  1,  0, 0, 0,  1,  0, 0};
    tbl[3]  = '{0, 0, 0,  1,   0,  0,  0,  0, 0, 0,  1,  1, 0};
    tbl[4]  = '{0, 0, 0,  1,   0,  1,  0,  0, 0, 0,  1,  1, 0};
    tbl[5]  = '{0, 0, 0,  1,   0,  0,  0,  0, 0, 0,  1,  1, 1};
    tbl[6]  = '{0, 0, 0,  1,   0,  0,  0,  1, 0, 0,  0,  1, 1};
    tbl[7]  = '{0, 0, 0,  1,   1,  0,  0,  0, 0, 0,  0,  1, 1};
    tbl[8]  = '{0, 1, 7,  0,   1,  0,  0,  0, 1, 0,  0,  1, 1};
    tbl[9]  = '{0, 0, 0,  0,   1,  0,  0,  0, 0, 0,  0,  1, 1};
    tbl[10] = '{0, 1, 0,  0,   0,  0,  0,  1, 0, 0,  0,  1, 1};
    tbl[11] = '{0, 0, 0,  0,   1,  0,  0,  0, 0, 0,  0,  1, 1};

    for (int i = 0; i < 12; i++) begin
      string t;
      t = $sformatf("tbl%0d", i);
      step(t, tbl[i].rst, tbl[i].v, tbl[i].amt, tbl[i].ack);
      chk({t, " T.ready"}, int'(chg_ready), int'(tbl[i].ready));
      chk({t, " T.req"},   int'(coin_req),  int'(tbl[i].req));
      chk({t, " T.sel"},   int'(coin_sel),  int'(tbl[i].sel));
      chk({t, " T.done"},  int'(done),      int'(tbl[i].dn));
      chk({t, " T.err"},   int'(err),       int'(tbl[i].er));
      chk({t, " T.fault"}, int'(fault),     int'(tbl[i].flt));
      chk({t, " T.busy"},  int'(busy),      int'(tbl[i].bsy));
      chk({t, " T.cnt10"}, int'(cnt10),     tbl[i].c10);
      chk({t, " T.cnt5"},  int'(cnt5),      tbl[i].c5);
    end

    // Amount 5, hopper acks on the third request cycle
    step("r5", 1, 0, 0, 0);
    nreq = 0;
    step("a5", 0, 1, 5, 0); nreq += int'(coin_req);
    step("a5", 0, 0, 0, 0); nreq += int'(coin_req);
    step("a5", 0, 0, 0, 0); nreq += int'(coin_req);
    step("a5", 0, 0, 0, 1); nreq += int'(coin_req);
    step("a5", 0, 0, 0, 0); nreq += int'(coin_req);
    chk("a5 done2", int'(done), 1);
    step("a5", 0, 0, 0, 0); nreq += int'(coin_req);
    chk("a5 reqcycles", nreq, 3);
    chk("a5 cnt5", int'(cnt5), 1);

    // Amount 10, hopper never acks: timeout fault, sticky until reset
    nreq = 0;
    step("to", 0, 1, 10, 0); nreq += int'(coin_req);
    for (int i = 0; i < 14; i++) begin
      step("to", 0, 1, 5, 0); nreq += int'(coin_req);
    end
    chk("to reqcycles", nreq, TO);
    chk("to fault", int'(fault), 1);
    chk("to ready", int'(chg_ready), 0);
    step("to rst", 1, 0, 0, 0);
    chk("to clr fault", int'(fault), 0);
    chk("to clr ready", int'(chg_ready), 1);
    step("to", 0, 0, 0, 0);

    // Ack pulse while idle changes nothing
    step("idleack", 0, 0, 0, 1);
    step("idleack", 0, 0, 0, 0);
    chk("idleack cnt5", int'(cnt5), 0);

    // Reset during the gap of a 15 payout, then a clean 10 payout
    step("rg", 0, 1, 15, 1);
    step("rg", 0, 0, 0, 1);
    chk("rg in gap", int'(busy && !coin_req), 1);
    step("rg rst", 1, 0, 0, 0);
    chk("rg done", int'(done), 0);
    chk("rg cnt10", int'(cnt10), 0);
    step("rg", 0, 1, 10, 1);
    for (int i = 0; i < 4; i++) step("rg", 0, 0, 0, 1);
    chk("rg cnt10 after", int'(cnt10), 1);
    chk("rg ready after", int'(chg_ready), 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, v, k;
      logic [3:0] a;
      r = ($urandom_range(0, 149) == 0);
      v = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) a = 4'($urandom_range(0, 15));
      else                          a = 4'($urandom_range(0, 3) * 5);
      k = ($urandom_range(0, 2) != 0);
      step("rnd", r, v, a, k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
